// File: rtl/main.sv
// main: five-stage pipelined MIPS-subset core (IF, ID, EX, MEM, WB) with full
// EX forwarding, ID-stage branch/jump resolution, load-use and branch-operand
// stalls, and one-cycle flush on taken control transfers.
// Ports:
//   clk        rising-edge clock for all state
//   rst        asynchronous active-high reset; clears the pipeline, sets PC = 0,
//              loads rf from regMem and zeroes dmem
//   instMemory word-indexed instruction ROM (65536 x 32)
//   regMem     initial register file image (32 x 32)
// The core has no functional outputs; rf and dmem are observed hierarchically.
module main (
    input logic        clk,
    input logic        rst,
    input logic [31:0] instMemory [0:65535],
    input logic [31:0] regMem     [0:31]
);
    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL} alu_op_t;

    logic [31:0] rf   [0:31];
    logic [31:0] dmem [0:1023];

    logic [31:0] pc, pc4, if_instr;
    logic [31:0] if_id_instr, if_id_pc4;

    logic        id_ex_regwrite, id_ex_memread, id_ex_memwrite, id_ex_alusrc;
    alu_op_t     id_ex_op;
    logic [31:0] id_ex_a, id_ex_b, id_ex_imm;
    logic [4:0]  id_ex_rs, id_ex_rt, id_ex_dst, id_ex_shamt;

    logic        ex_mem_regwrite, ex_mem_memread, ex_mem_memwrite;
    logic [4:0]  ex_mem_dst;
    logic [31:0] ex_mem_alu, ex_mem_sdata;

    logic        mem_wb_regwrite;
    logic [4:0]  mem_wb_dst;
    logic [31:0] mem_wb_result;

    assign pc4      = pc + 32'd4;
    assign if_instr = instMemory[pc[17:2]];

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] imm;
    logic        is_r, is_lw, is_sw, is_addi, is_beq, is_j;
    alu_op_t     op;

    assign opcode  = if_id_instr[31:26];
    assign rs      = if_id_instr[25:21];
    assign rt      = if_id_instr[20:16];
    assign rd      = if_id_instr[15:11];
    assign shamt   = if_id_instr[10:6];
    assign funct   = if_id_instr[5:0];
    assign imm     = {{16{if_id_instr[15]}}, if_id_instr[15:0]};
    assign is_r    = opcode == 6'h00 && (funct == 6'h20 || funct == 6'h22 || funct == 6'h24 ||
                                         funct == 6'h25 || funct == 6'h2A || funct == 6'h00);
    assign is_lw   = opcode == 6'h23;
    assign is_sw   = opcode == 6'h2B;
    assign is_addi = opcode == 6'h08;
    assign is_beq  = opcode == 6'h04;
    assign is_j    = opcode == 6'h02;

    always_comb begin
        op = ALU_ADD;
        if (is_r)
            op = funct == 6'h22 ? ALU_SUB :
                 funct == 6'h24 ? ALU_AND :
                 funct == 6'h25 ? ALU_OR  :
                 funct == 6'h2A ? ALU_SLT :
                 funct == 6'h00 ? ALU_SLL : ALU_ADD;
    end

    // Register read with write-through from WB so a same-cycle write is seen.
    logic [31:0] rd_rs, rd_rt;
    assign rd_rs = rs == 5'd0 ? 32'd0 : (mem_wb_regwrite && mem_wb_dst == rs) ? mem_wb_result : rf[rs];
    assign rd_rt = rt == 5'd0 ? 32'd0 : (mem_wb_regwrite && mem_wb_dst == rt) ? mem_wb_result : rf[rt];

    logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
    assign ex_hit_rs  = id_ex_regwrite  && id_ex_dst  != 5'd0 && id_ex_dst  == rs;
    assign ex_hit_rt  = id_ex_regwrite  && id_ex_dst  != 5'd0 && id_ex_dst  == rt;
    assign mem_hit_rs = ex_mem_regwrite && ex_mem_dst != 5'd0 && ex_mem_dst == rs;
    assign mem_hit_rt = ex_mem_regwrite && ex_mem_dst != 5'd0 && ex_mem_dst == rt;

    // Branch comparator sees ALU results already in EX/MEM; a load there is
    // not ready yet, which the stall below covers.
    logic [31:0] cmp_a, cmp_b;
    assign cmp_a = (mem_hit_rs && !ex_mem_memread) ? ex_mem_alu : rd_rs;
    assign cmp_b = (mem_hit_rt && !ex_mem_memread) ? ex_mem_alu : rd_rt;

    logic uses_rs, uses_rt, load_use, beq_stall, stall, redirect;
    logic [31:0] target;
    assign uses_rs   = is_r || is_lw || is_sw || is_addi || is_beq;
    assign uses_rt   = is_r || is_sw || is_beq;
    assign load_use  = id_ex_memread && ((uses_rs && ex_hit_rs) || (uses_rt && ex_hit_rt));
    // Any producer in EX stalls beq once; a load then stalls it again from MEM.
    assign beq_stall = is_beq && (ex_hit_rs || ex_hit_rt || (ex_mem_memread && (mem_hit_rs || mem_hit_rt)));
    assign stall     = load_use || beq_stall;
    assign redirect  = !stall && (is_j || (is_beq && cmp_a == cmp_b));
    assign target    = is_j ? {if_id_pc4[31:28], if_id_instr[25:0], 2'b00} : if_id_pc4 + (imm << 2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= 32'd0;
            if_id_instr <= 32'd0;
            if_id_pc4   <= 32'd0;
        end else if (!stall) begin
            pc          <= redirect ? target : pc4;
            if_id_instr <= redirect ? 32'd0 : if_instr;
            if_id_pc4   <= pc4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_ex_regwrite <= 1'b0;
            id_ex_memread  <= 1'b0;
            id_ex_memwrite <= 1'b0;
            id_ex_alusrc   <= 1'b0;
            id_ex_op       <= ALU_ADD;
            id_ex_a        <= 32'd0;
            id_ex_b        <= 32'd0;
            id_ex_imm      <= 32'd0;
            id_ex_rs       <= 5'd0;
            id_ex_rt       <= 5'd0;
            id_ex_dst      <= 5'd0;
            id_ex_shamt    <= 5'd0;
        end else begin
            id_ex_regwrite <= !stall && (is_r || is_lw || is_addi);
            id_ex_memread  <= !stall && is_lw;
            id_ex_memwrite <= !stall && is_sw;
            id_ex_alusrc   <= is_lw || is_sw || is_addi;
            id_ex_op       <= op;
            id_ex_a        <= rd_rs;
            id_ex_b        <= rd_rt;
            id_ex_imm      <= imm;
            id_ex_rs       <= rs;
            id_ex_rt       <= rt;
            id_ex_dst      <= is_r ? rd : rt;
            id_ex_shamt    <= shamt;
        end
    end

    logic [31:0] fwd_a, fwd_b, alu_b, alu;
    assign fwd_a = (ex_mem_regwrite && ex_mem_dst != 5'd0 && ex_mem_dst == id_ex_rs) ? ex_mem_alu :
                   (mem_wb_regwrite && mem_wb_dst != 5'd0 && mem_wb_dst == id_ex_rs) ? mem_wb_result : id_ex_a;
    assign fwd_b = (ex_mem_regwrite && ex_mem_dst != 5'd0 && ex_mem_dst == id_ex_rt) ? ex_mem_alu :
                   (mem_wb_regwrite && mem_wb_dst != 5'd0 && mem_wb_dst == id_ex_rt) ? mem_wb_result : id_ex_b;
    assign alu_b = id_ex_alusrc ? id_ex_imm : fwd_b;
    assign alu   = id_ex_op == ALU_SUB ? fwd_a - alu_b :
                   id_ex_op == ALU_AND ? fwd_a & alu_b :
                   id_ex_op == ALU_OR  ? fwd_a | alu_b :
                   id_ex_op == ALU_SLT ? {31'd0, $signed(fwd_a) < $signed(alu_b)} :
                   id_ex_op == ALU_SLL ? fwd_b << id_ex_shamt : fwd_a + alu_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_mem_regwrite <= 1'b0;
            ex_mem_memread  <= 1'b0;
            ex_mem_memwrite <= 1'b0;
            ex_mem_dst      <= 5'd0;
            ex_mem_alu      <= 32'd0;
            ex_mem_sdata    <= 32'd0;
        end else begin
            ex_mem_regwrite <= id_ex_regwrite;
            ex_mem_memread  <= id_ex_memread;
            ex_mem_memwrite <= id_ex_memwrite;
            ex_mem_dst      <= id_ex_dst;
            ex_mem_alu      <= alu;
            ex_mem_sdata    <= fwd_b;
        end
    end

    logic [31:0] load_data;
    assign load_data = dmem[ex_mem_alu[9:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) dmem[i] <= 32'd0;
        end else if (ex_mem_memwrite) begin
            dmem[ex_mem_alu[9:0]] <= ex_mem_sdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_wb_regwrite <= 1'b0;
            mem_wb_dst      <= 5'd0;
            mem_wb_result   <= 32'd0;
        end else begin
            mem_wb_regwrite <= ex_mem_regwrite;
            mem_wb_dst      <= ex_mem_dst;
            mem_wb_result   <= ex_mem_memread ? load_data : ex_mem_alu;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= regMem[i];
        end else if (mem_wb_regwrite && mem_wb_dst != 5'd0) begin
            rf[mem_wb_dst] <= mem_wb_result;
        end
    end
endmodule

// File: tb/tb_main.sv
// tb_main: directed and randomized programs for the pipelined core, checked
// against an instruction-level interpreter of the same programs.
module tb_main;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] imem [0:65535];
    logic [31:0] regs [0:31];
    logic [31:0] m_rf [0:31];
    logic [31:0] m_dmem [0:1023];
    logic [5:0]  fn_tab [0:5];
    int checks = 0;
    int errors = 0;

    main dut (.clk(clk), .rst(rst), .instMemory(imem), .regMem(regs));

    always #5 clk = ~clk;

    function automatic logic [31:0] rr(input logic [5:0] f, input logic [4:0] s, input logic [4:0] t,
                                       input logic [4:0] d, input logic [4:0] sh);
        return {6'h00, s, t, d, sh, f};
    endfunction

    function automatic logic [31:0] ii(input logic [5:0] o, input logic [4:0] s, input logic [4:0] t,
                                       input logic [15:0] im);
        return {o, s, t, im};
    endfunction

    function automatic logic [31:0] jj(input logic [25:0] a);
        return {6'h02, a};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Sequential interpreter; a jump to itself marks the end of a program.
    task automatic model_run();
        logic [31:0] pc, npc, w, a, b, im, addr, res;
        logic [4:0]  dst;
        logic        wr;
        pc = 32'd0;
        for (int i = 0; i < 32; i++) m_rf[i] = regs[i];
        for (int i = 0; i < 1024; i++) m_dmem[i] = 32'd0;
        for (int n = 0; n < 2000; n++) begin
            w   = imem[pc[17:2]];
            npc = pc + 32'd4;
            if (w[31:26] == 6'h02 && {npc[31:28], w[25:0], 2'b00} == pc) break;
            a    = m_rf[w[25:21]];
            b    = m_rf[w[20:16]];
            im   = {{16{w[15]}}, w[15:0]};
            addr = a + im;
            wr   = 1'b0;
            dst  = w[20:16];
            res  = 32'd0;
            case (w[31:26])
                6'h00: begin
                    dst = w[15:11];
                    wr  = 1'b1;
                    case (w[5:0])
                        6'h20: res = a + b;
                        6'h22: res = a - b;
                        6'h24: res = a & b;
                        6'h25: res = a | b;
                        6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        6'h00: res = b << w[10:6];
                        default: wr = 1'b0;
                    endcase
                end
                6'h08: begin wr = 1'b1; res = addr; end
                6'h23: begin wr = 1'b1; res = m_dmem[addr[9:0]]; end
                6'h2B: m_dmem[addr[9:0]] = b;
                6'h04: if (a == b) npc = npc + (im << 2);
                6'h02: npc = {npc[31:28], w[25:0], 2'b00};
                default: ;
            endcase
            if (wr && dst != 5'd0) m_rf[dst] = res;
            pc = npc;
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 32; i++) check($sformatf("%s rf[%0d]", tag, i), dut.rf[i], m_rf[i]);
        for (int i = 0; i < 1024; i++) check($sformatf("%s dmem[%0d]", tag, i), dut.dmem[i], m_dmem[i]);
    endtask

    task automatic check_rf_init(input string tag);
        for (int i = 0; i < 32; i++) check($sformatf("%s rf[%0d]", tag, i), dut.rf[i], regs[i]);
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) imem[i] = 32'd0;
    endtask

    task automatic default_regs();
        for (int i = 0; i < 32; i++) regs[i] = 32'(i);
    endtask

    // Leaves the bench on a falling edge with rst low; the next rising edge fetches PC 0.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic gen_random(input int len);
        int kind, off;
        logic [4:0] s, t, d;
        clear_prog();
        for (int k = 0; k < len; k++) begin
            kind = $urandom_range(0, 9);
            s = 5'($urandom_range(0, 7));
            t = 5'($urandom_range(0, 7));
            d = 5'($urandom_range(0, 7));
            if (kind <= 4) imem[k] = rr(fn_tab[$urandom_range(0, 5)], s, t, d, 5'($urandom_range(0, 31)));
            else if (kind == 5) imem[k] = ii(6'h08, s, t, 16'($urandom));
            else if (kind == 6) imem[k] = ii(6'h23, s, t, 16'($urandom_range(0, 8)));
            else if (kind == 7) imem[k] = ii(6'h2B, s, t, 16'($urandom_range(0, 8)));
            else if (kind == 8) begin
                off = $urandom_range(0, len - k - 1);
                imem[k] = ii(6'h04, s, $urandom_range(0, 1) ? s : t, 16'(off));
            end else begin
                off = $urandom_range(0, 2);
                imem[k] = off == 0 ? jj(26'($urandom_range(k + 1, len))) :
                          off == 1 ? ii(6'h3F, s, t, 16'($urandom)) : rr(6'h01, s, t, d, 5'd0);
            end
        end
        imem[len] = jj(26'(len));
        regs[0] = 32'd0;
        for (int i = 1; i < 32; i++) regs[i] = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 8));
    endtask

    initial begin
        fn_tab[0] = 6'h20; fn_tab[1] = 6'h22; fn_tab[2] = 6'h24;
        fn_tab[3] = 6'h25; fn_tab[4] = 6'h2A; fn_tab[5] = 6'h00;
        for (int i = 0; i < 65536; i++) imem[i] = 32'd0;
        default_regs();

        // Basic ALU program
        imem[0] = rr(6'h20, 5'd1, 5'd0, 5'd3, 5'd0);
        imem[1] = 32'd0;
        imem[2] = rr(6'h22, 5'd5, 5'd4, 5'd6, 5'd0);
        imem[3] = rr(6'h24, 5'd7, 5'd8, 5'd9, 5'd0);
        imem[4] = rr(6'h25, 5'd10, 5'd11, 5'd12, 5'd0);
        imem[5] = rr(6'h2A, 5'd13, 5'd14, 5'd15, 5'd0);
        imem[6] = jj(26'd6);
        model_run();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_rf_init("reset");
        do_reset();
        run(30);
        check("alu R3", dut.rf[3], 32'd1);
        check("alu R6", dut.rf[6], 32'd1);
        check("alu R9", dut.rf[9], 32'd0);
        check("alu R12", dut.rf[12], 32'd11);
        check("alu R15", dut.rf[15], 32'd1);
        check_all("alu");

        // Forwarding chain: the third add retires on the 7th edge, proving no stall
        clear_prog();
        default_regs();
        regs[5] = 32'd0;
        imem[0] = rr(6'h20, 5'd1, 5'd2, 5'd3, 5'd0);
        imem[1] = rr(6'h20, 5'd2, 5'd3, 5'd4, 5'd0);
        imem[2] = rr(6'h20, 5'd3, 5'd4, 5'd5, 5'd0);
        imem[3] = jj(26'd3);
        model_run();
        do_reset();
        run(6);
        check("fwd R5 before wb", dut.rf[5], 32'd0);
        run(1);
        check("fwd R5 at wb", dut.rf[5], 32'd8);
        run(20);
        check("fwd R3", dut.rf[3], 32'd3);
        check("fwd R4", dut.rf[4], 32'd5);
        check_all("fwd");

        // sll, lw, then sw stalled once on the load; trailing addi shows the delay
        clear_prog();
        default_regs();
        regs[15] = 32'd1;
        imem[0] = 32'h00221800;
        imem[1] = ii(6'h23, 5'd15, 5'd16, 16'd3);
        imem[2] = ii(6'h2B, 5'd16, 5'd16, 16'hC003);
        imem[3] = ii(6'h08, 5'd0, 5'd20, 16'd7);
        imem[4] = jj(26'd4);
        model_run();
        do_reset();
        run(8);
        check("lu R20 held by stall", dut.rf[20], 32'd20);
        run(1);
        check("lu R20 after stall", dut.rf[20], 32'd7);
        check("lu R3", dut.rf[3], 32'd2);
        check("lu R16", dut.rf[16], 32'd0);
        check("lu dmem3", dut.dmem[3], 32'd0);
        run(20);
        check_all("lu");

        // Jump back to 0 forever; the word after the jump must never retire
        clear_prog();
        default_regs();
        imem[0] = rr(6'h20, 5'd1, 5'd0, 5'd3, 5'd0);
        imem[2] = rr(6'h22, 5'd5, 5'd4, 5'd6, 5'd0);
        imem[3] = rr(6'h24, 5'd7, 5'd8, 5'd9, 5'd0);
        imem[4] = rr(6'h25, 5'd10, 5'd11, 5'd12, 5'd0);
        imem[5] = rr(6'h2A, 5'd13, 5'd14, 5'd15, 5'd0);
        imem[14] = jj(26'd14);
        imem[15] = ii(6'h08, 5'd0, 5'd31, 16'd99);
        model_run();
        imem[14] = jj(26'd0);
        do_reset();
        run(100);
        check("jump R31", dut.rf[31], 32'd31);
        check_all("jump");

        // beq taken: skips two words with one flush cycle
        clear_prog();
        default_regs();
        imem[0] = ii(6'h04, 5'd1, 5'd1, 16'd2);
        imem[1] = ii(6'h08, 5'd0, 5'd20, 16'd1);
        imem[2] = ii(6'h08, 5'd0, 5'd21, 16'd1);
        imem[3] = ii(6'h08, 5'd0, 5'd22, 16'd5);
        imem[4] = jj(26'd4);
        model_run();
        do_reset();
        run(6);
        check("beq taken R22 early", dut.rf[22], 32'd22);
        run(1);
        check("beq taken R22", dut.rf[22], 32'd5);
        run(20);
        check("beq taken R20", dut.rf[20], 32'd20);
        check("beq taken R21", dut.rf[21], 32'd21);
        check_all("beq taken");

        // beq not taken: falls through
        imem[0] = ii(6'h04, 5'd1, 5'd2, 16'd2);
        model_run();
        do_reset();
        run(7);
        check("beq nt R22 early", dut.rf[22], 32'd22);
        run(1);
        check("beq nt R22", dut.rf[22], 32'd5);
        run(20);
        check("beq nt R20", dut.rf[20], 32'd1);
        check("beq nt R21", dut.rf[21], 32'd1);
        check_all("beq nt");

        // Writes aimed at R0 are discarded and never forwarded
        clear_prog();
        default_regs();
        imem[0] = ii(6'h08, 5'd0, 5'd0, 16'd5);
        imem[1] = rr(6'h20, 5'd1, 5'd2, 5'd0, 5'd0);
        imem[2] = rr(6'h20, 5'd0, 5'd0, 5'd3, 5'd0);
        imem[3] = ii(6'h08, 5'd0, 5'd4, 16'd1);
        imem[4] = jj(26'd4);
        model_run();
        do_reset();
        run(25);
        check("r0 R0", dut.rf[0], 32'd0);
        check("r0 R3", dut.rf[3], 32'd0);
        check("r0 R4", dut.rf[4], 32'd1);
        check_all("r0");

        // Reset mid-program: rf reloads asynchronously, in-flight writes are lost
        gen_random(40);
        model_run();
        do_reset();
        run(15);
        #2;
        rst = 1'b1;
        #1;
        check_rf_init("midrst async");
        run(2);
        check_rf_init("midrst held");
        @(negedge clk);
        rst = 1'b0;
        run(300);
        check_all("midrst rerun");

        // Random programs
        for (int p = 0; p < 8; p++) begin
            gen_random(40);
            model_run();
            do_reset();
            run(300);
            check_all($sformatf("rand%0d", p));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
